// File: rtl/rvfi_retire_fifo.sv
// Multi-lane retire FIFO: packs up to NR_PORTS retired records per cycle into a ring,
// drops what does not fit, and presents one record per cycle with a running order number.
module rvfi_retire_lane #(
  parameter int AW = 4,
  parameter int OW = 5
) (
  input  logic          valid_i,
  input  logic [OW-1:0] idx_i,
  input  logic [OW-1:0] free_i,
  input  logic [AW-1:0] wptr_i,
  output logic          store_o,
  output logic [AW-1:0] slot_o
);
  // idx_i is the number of valid lanes below this one, so valid lanes pack densely.
  assign store_o = valid_i && (idx_i < free_i);
  assign slot_o  = wptr_i + idx_i[AW-1:0];
endmodule

module rvfi_retire_fifo #(
  parameter int NR_PORTS = 2,
  parameter int REC_W    = 256,
  parameter int DEPTH    = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic [NR_PORTS-1:0]            in_valid_i,
  input  logic [NR_PORTS-1:0][REC_W-1:0] in_rec_i,
  output logic                           out_valid_o,
  output logic [REC_W-1:0]               out_rec_o,
  output logic [63:0]                    out_order_o,
  input  logic                           out_ready_i,
  output logic [$clog2(DEPTH):0]         occupancy_o,
  output logic [31:0]                    drop_cnt_o,
  output logic                           overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OW-1:0] occ_q, occ_d, free, n_vld, n_st, n_drop;
  logic [31:0]   drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic [63:0]   order_q, order_d;
  logic [32:0]   drop_sum;
  logic          pop;

  logic [NR_PORTS-1:0][OW-1:0] idx;
  logic [NR_PORTS-1:0][AW-1:0] slot;
  logic [NR_PORTS-1:0]         store;

  // Space is judged against start-of-cycle occupancy; a same-cycle pop does not help.
  assign free = OW'(DEPTH) - occ_q;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    logic [OW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      idx[i] = acc;
      acc    = acc + OW'(in_valid_i[i]);
    end
    n_vld = acc;
  end

  for (genvar g = 0; g < NR_PORTS; g++) begin : g_lane
    rvfi_retire_lane #(.AW(AW), .OW(OW)) u_lane (
      .valid_i (in_valid_i[g]),
      .idx_i   (idx[g]),
      .free_i  (free),
      .wptr_i  (wptr_q),
      .store_o (store[g]),
      .slot_o  (slot[g])
    );
  end

  always_comb begin
    logic [OW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NR_PORTS; i++) acc = acc + OW'(store[i]);
    n_st = acc;
  end

  assign n_drop   = n_vld - n_st;
  assign drop_sum = {1'b0, drop_q} + 33'(n_drop);

  always_comb begin
    wptr_d  = wptr_q + n_st[AW-1:0];
    rptr_d  = rptr_q + AW'(pop);
    occ_d   = occ_q + n_st - OW'(pop);
    drop_d  = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    ovf_d   = ovf_q || (n_drop != '0);
    order_d = order_q + 64'(pop);
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      occ_d   = '0;
      drop_d  = '0;
      ovf_d   = 1'b0;
      order_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      order_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      order_q <= order_d;
    end
  end

  // Storage is not reset; the head is only meaningful while occupancy is nonzero.
  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      for (int i = 0; i < NR_PORTS; i++)
        if (store[i]) mem_q[slot[i]] <= in_rec_i[i];
    end
  end

  assign out_valid_o = (occ_q != '0);
  assign out_rec_o   = mem_q[rptr_q];
  assign out_order_o = order_q;
  assign occupancy_o = occ_q;
  assign drop_cnt_o  = drop_q;
  assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_rvfi_retire_fifo.sv
// Bench for rvfi_retire_fifo: a reference queue model plus a directed vector table
// and hand sequences for overflow, wrap, clear and asynchronous reset.
module tb_rvfi_retire_fifo;
  localparam int NP = 2;
  localparam int RW = 32;
  localparam int DP = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     clear;
  logic [NP-1:0]            in_valid;
  logic [NP-1:0][RW-1:0]    in_rec;
  logic                     out_valid;
  logic [RW-1:0]            out_rec;
  logic [63:0]              out_order;
  logic                     out_ready;
  logic [$clog2(DP):0]      occ;
  logic [31:0]              drop_cnt;
  logic                     ovf;

  rvfi_retire_fifo #(.NR_PORTS(NP), .REC_W(RW), .DEPTH(DP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_rec_i(in_rec),
    .out_valid_o(out_valid), .out_rec_o(out_rec), .out_order_o(out_order),
    .out_ready_i(out_ready), .occupancy_o(occ), .drop_cnt_o(drop_cnt), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [RW-1:0]   mq[$];
  longint unsigned m_drop;
  bit              m_ovf;
  longint unsigned m_order;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] a;
    logic [31:0] b;
    logic        rdy;
    logic        clr;
    int          e_occ;
    logic        e_valid;
    logic [31:0] e_rec;
    longint      e_order;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("occupancy", 64'(occ), 64'(mq.size()));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) chk("out_rec", 64'(out_rec), 64'(mq[0]));
    chk("out_order", out_order, m_order);
    chk("drop_cnt", 64'(drop_cnt), m_drop);
    chk("overflow", 64'(ovf), 64'(m_ovf));
  endtask

  task automatic model_reset();
    mq.delete();
    m_drop  = 0;
    m_ovf   = 0;
    m_order = 0;
  endtask

  // Advance the model by one edge using the inputs that were on the pins.
  task automatic model_edge(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                            input logic rdy, input logic clr);
    int  free, st;
    bit  pop;
    if (clr) begin
      model_reset();
      return;
    end
    pop  = (mq.size() != 0) && rdy;
    free = DP - mq.size();
    st   = 0;
    for (int l = 0; l < NP; l++) begin
      if (v[l]) begin
        if (st < free) begin
          mq.push_back(l == 0 ? a : b);
          st++;
        end else begin
          if (m_drop != 64'hFFFF_FFFF) m_drop++;
          m_ovf = 1;
        end
      end
    end
    if (pop) begin
      void'(mq.pop_front());
      m_order++;
    end
  endtask

  task automatic step(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                      input logic rdy, input logic clr);
    in_valid  = v;
    in_rec[0] = a;
    in_rec[1] = b;
    out_ready = rdy;
    clear     = clr;
    @(posedge clk);
    model_edge(v, a, b, rdy, clr);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = '0; in_rec = '0; out_ready = 1'b0;
    model_reset();
    #12;
    chk("reset occ", 64'(occ), 0);
    chk("reset valid", 64'(out_valid), 0);
    chk("reset drop", 64'(drop_cnt), 0);
    chk("reset order", out_order, 0);
    chk("reset ovf", 64'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-lane push then drain, followed by a lane-1-only push.
    tbl[0] = '{2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 1'b1, 1'b0, 2, 1'b1, 32'hAAAA_0001, 0};
    tbl[1] = '{2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 1, 1'b1, 32'hBBBB_0002, 1};
    tbl[2] = '{2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 0, 1'b0, 32'h0,         2};
    tbl[3] = '{2'b10, 32'hDEAD_DEAD, 32'hCCCC_0003, 1'b0, 1'b0, 1, 1'b1, 32'hCCCC_0003, 2};
    tbl[4] = '{2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 0, 1'b0, 32'h0,         3};
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d occ", i), 64'(occ), 64'(tbl[i].e_occ));
      chk($sformatf("tbl%0d valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("tbl%0d rec", i), 64'(out_rec), 64'(tbl[i].e_rec));
      chk($sformatf("tbl%0d order", i), out_order, 64'(tbl[i].e_order));
    end

    // 40 single-lane pushes with consumer stalled, then a full drain.
    step(2'b00, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) step(2'b01, 32'h1000 + i, 0, 0, 0);
    chk("fill occ", 64'(occ), 16);
    chk("fill drop", 64'(drop_cnt), 24);
    chk("fill ovf", 64'(ovf), 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain order", out_order, 64'(i));
      chk("drain rec", 64'(out_rec), 64'(32'h1000 + i));
      step(2'b00, 0, 0, 1, 0);
    end
    chk("drained valid", 64'(out_valid), 0);

    // Occupancy 15, two lanes in, pop same cycle: pop does not free space.
    step(2'b00, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) step(2'b01, 32'h2000 + i, 0, 0, 0);
    step(2'b11, 32'h2F00, 32'h2F01, 1, 0);
    chk("edge occ", 64'(occ), 15);
    chk("edge drop", 64'(drop_cnt), 1);
    chk("edge ovf", 64'(ovf), 1);

    // Random traffic across pointer wrap, then clear with live inputs.
    step(2'b00, 0, 0, 0, 1);
    for (int i = 0; i < 80; i++)
      step(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 3) != 0), 0);
    for (int i = 0; i < 12; i++) step(2'b11, 32'h3000 + 2 * i, 32'h3001 + 2 * i, 0, 0);
    step(2'b11, 32'h4444, 32'h5555, 1, 1);
    chk("clear valid", 64'(out_valid), 0);
    chk("clear drop", 64'(drop_cnt), 0);
    chk("clear order", out_order, 0);
    chk("clear occ", 64'(occ), 0);

    // Async reset between edges with five entries held.
    for (int i = 0; i < 5; i++) step(2'b01, 32'h6000 + i, 0, 0, 0);
    step(2'b00, 0, 0, 1, 0);
    @(posedge clk);
    model_edge(2'b00, 0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset occ", 64'(occ), 0);
    chk("areset valid", 64'(out_valid), 0);
    chk("areset order", out_order, 0);
    chk("areset drop", 64'(drop_cnt), 0);
    chk("areset ovf", 64'(ovf), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b01, 32'h7777_0000, 0, 0, 0);
    chk("post-reset order", out_order, 0);
    chk("post-reset rec", 64'(out_rec), 64'(32'h7777_0000));
    step(2'b00, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
